// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one registered ALU through an IDLE/ISSUE/WAIT/RESP FSM.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 first); default is round-robin.
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [2:0]            req0_opselect,
    input  logic [2:0]            req0_operation,
    input  logic [DATA_WIDTH-1:0] req0_op1,
    input  logic [DATA_WIDTH-1:0] req0_op2,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [2:0]            req1_opselect,
    input  logic [2:0]            req1_operation,
    input  logic [DATA_WIDTH-1:0] req1_op1,
    input  logic [DATA_WIDTH-1:0] req1_op2,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_carry,
    output logic                  rsp_err,
    output logic                  alu_enable,
    output logic [2:0]            alu_opselect,
    output logic [2:0]            alu_operation,
    output logic [DATA_WIDTH-1:0] aluin1,
    output logic [DATA_WIDTH-1:0] aluin2,
    output logic                  alu_reset_n,
    input  logic [DATA_WIDTH-1:0] aluout_arith,
    input  logic                  carry,
    output logic                  busy
);
    localparam int unsigned OP_W = 3;
    localparam logic [OP_W-1:0] SEL_ARITH_LOGIC = OP_W'(3'b001);
    localparam logic [OP_W-1:0] SEL_MEM_READ    = OP_W'(3'b101);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  grant_q, grant_d;
    logic [OP_W-1:0]       alu_sel_q, alu_sel_d;
    logic [OP_W-1:0]       alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0] in1_q, in1_d;
    logic [DATA_WIDTH-1:0] in2_q, in2_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                  res_carry_q, res_carry_d;
    logic                  res_err_q, res_err_d;

    logic                  pick_c;
    logic                  accept_c;
    logic                  rsp_hs_c;
    logic [OP_W-1:0]       sel_c;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic                  ptr_q, ptr_d;
`endif

    // Winning port (1 = port 1); only meaningful when some request is valid
    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        pick_c = ~req0_valid;
`else
        pick_c = (req0_valid & req1_valid) ? ptr_q : ~req0_valid;
`endif
    end

    assign accept_c = ~reset & (state_q == IDLE) & (req0_valid | req1_valid);
    assign sel_c    = pick_c ? req1_opselect : req0_opselect;
    assign rsp_hs_c = (state_q == RESP) & (grant_q ? rsp1_ready : rsp0_ready);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        alu_sel_d   = alu_sel_q;
        alu_op_d    = alu_op_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_err_d   = res_err_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    grant_d = pick_c;
                    if ((sel_c == SEL_ARITH_LOGIC) || (sel_c == SEL_MEM_READ)) begin
                        alu_sel_d = sel_c;
                        alu_op_d  = pick_c ? req1_operation : req0_operation;
                        in1_d     = pick_c ? req1_op1 : req0_op1;
                        in2_d     = pick_c ? req1_op2 : req0_op2;
                        res_err_d = 1'b0;
                        state_d   = ISSUE;
                    end else begin
                        // Unsupported class: answer with an error, ALU untouched
                        res_data_d  = '0;
                        res_carry_d = 1'b0;
                        res_err_d   = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                res_data_d  = aluout_arith;
                res_carry_d = carry;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_hs_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            alu_sel_q   <= '0;
            alu_op_q    <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            alu_sel_q   <= alu_sel_d;
            alu_op_q    <= alu_op_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_err_q   <= res_err_d;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Pointer flips on every completed response handshake
    always_comb begin
        ptr_d = ptr_q;
        if (rsp_hs_c) begin
            ptr_d = ~ptr_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Every output is forced low while reset is high
    assign req0_ready    = accept_c & ~pick_c;
    assign req1_ready    = accept_c & pick_c;
    assign rsp0_valid    = ~reset & (state_q == RESP) & ~grant_q;
    assign rsp1_valid    = ~reset & (state_q == RESP) & grant_q;
    assign rsp_data      = reset ? '0 : res_data_q;
    assign rsp_carry     = ~reset & res_carry_q;
    assign rsp_err       = ~reset & res_err_q;
    assign alu_enable    = ~reset & (state_q == ISSUE);
    assign alu_opselect  = reset ? '0 : alu_sel_q;
    assign alu_operation = reset ? '0 : alu_op_q;
    assign aluin1        = reset ? '0 : in1_q;
    assign aluin2        = reset ? '0 : in2_q;
    assign alu_reset_n   = ~reset;
    assign busy          = ~reset & (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector table, hand sequences and a randomized run against a
// transaction-level model of the arbiter; includes a registered ALU stand-in.
module tb_alu_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0]  req0_opselect, req0_operation, req1_opselect, req1_operation;
    logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp_data;
    logic        rsp_carry, rsp_err;
    logic        alu_enable;
    logic [2:0]  alu_opselect, alu_operation;
    logic [31:0] aluin1, aluin2;
    logic        alu_reset_n;
    logic [31:0] aluout_arith;
    logic        carry;
    logic        busy;

    int checks   = 0;
    int failures = 0;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    always #5 clock = ~clock;

    alu_arbiter #(.DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_opselect(req0_opselect), .req0_operation(req0_operation),
        .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_opselect(req1_opselect), .req1_operation(req1_operation),
        .req1_op1(req1_op1), .req1_op2(req1_op2),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .alu_enable(alu_enable), .alu_opselect(alu_opselect), .alu_operation(alu_operation),
        .aluin1(aluin1), .aluin2(aluin2), .alu_reset_n(alu_reset_n),
        .aluout_arith(aluout_arith), .carry(carry), .busy(busy)
    );

    // ALU behaviour: {carry, result}
    function automatic logic [32:0] alu_ref(input logic [2:0] sel, input logic [2:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        if (sel == 3'b101) return {1'b0, a ^ 32'hA5A5_0000};
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {a < b, a - b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            default: return {1'b0, ~a};
        endcase
    endfunction

    // Registered ALU; drives junk on cycles without enable so mistimed captures show up
    always @(posedge clock) begin
        if (!alu_reset_n) begin
            aluout_arith <= '0;
            carry        <= 1'b0;
        end else if (alu_enable) begin
            {carry, aluout_arith} <= alu_ref(alu_opselect, alu_operation, aluin1, aluin2);
        end else begin
            aluout_arith <= $urandom;
            carry        <= 1'($urandom);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [2:0] s, input logic [2:0] o,
                           input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req0_valid = v; req0_opselect = s; req0_operation = o; req0_op1 = a; req0_op2 = b;
        end else begin
            req1_valid = v; req1_opselect = s; req1_operation = o; req1_op1 = a; req1_op2 = b;
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic rspv(input int p);
        return (p == 0) ? rsp0_valid : rsp1_valid;
    endfunction

    function automatic logic [63:0] outs_pack();
        return 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_carry, rsp_err,
                    alu_enable, alu_opselect, alu_operation, busy, alu_reset_n});
    endfunction

    task automatic apply_reset();
        cyc();
        reset = 1'b1;
        set_req(0, 1'b1, 3'b001, 3'b000, 32'd1, 32'd2);
        set_req(1, 1'b1, 3'b001, 3'b000, 32'd3, 32'd4);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        @(negedge clock);
        check("reset_outputs", outs_pack(), 64'd0);
        check("reset_aluin", {aluin1, aluin2}, 64'd0);
        cyc();
        reset = 1'b0;
        drop(0);
        drop(1);
        @(negedge clock);
        check("post_reset_alu_reset_n_busy", 64'({alu_reset_n, busy}), 64'(2'b10));
    endtask

    // Wait from the cycle after accept until the port's response is seen (bounded)
    task automatic wait_rsp(input int p, output int lat);
        lat = 1;
        @(negedge clock);
        while (!rspv(p) && lat < 10) begin
            @(negedge clock);
            lat++;
        end
    endtask

    typedef struct {
        int          port;
        logic [2:0]  sel;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        c;
        logic        e;
    } vec_t;

    task automatic run_op(input vec_t t, input int idx);
        int n, lat, en;
        cyc();
        set_req(t.port, 1'b1, t.sel, t.op, t.a, t.b);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        n = 0;
        @(negedge clock);
        while (!rdy(t.port) && n < 20) begin
            @(negedge clock);
            n++;
        end
        check($sformatf("v%0d_accept", idx), 64'(rdy(t.port)), 64'd1);
        cyc();
        drop(t.port);
        lat = 1;
        en  = 0;
        @(negedge clock);
        while (!rspv(t.port) && lat < 10) begin
            en += int'(alu_enable);
            @(negedge clock);
            lat++;
        end
        check($sformatf("v%0d_latency", idx), 64'(lat), 64'(t.e ? 1 : 3));
        check($sformatf("v%0d_alu_enable_count", idx), 64'(en), 64'(t.e ? 0 : 1));
        check($sformatf("v%0d_result", idx), 64'({rsp_err, rsp_carry, rsp_data}),
              64'({t.e, t.c, t.d}));
        cyc();
    endtask

    vec_t vecs[10];

    // Random-run state
    logic        rv[2];
    logic [2:0]  rs[2], ro[2];
    logic [31:0] ra[2], rb[2];
    bit          m_busy, m_ptr;
    int          m_port, m_age, m_lat;
    logic [2:0]  m_sel, m_op;
    logic [31:0] m_a, m_b, m_d;
    logic        m_c, m_e;

    initial begin
        int lat, w, o;
        logic [1:0] exp_rdy;
        logic [1:0] exp_rv;

        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_opselect = '0; req0_operation = '0; req0_op1 = '0; req0_op2 = '0;
        req1_opselect = '0; req1_operation = '0; req1_op1 = '0; req1_op2 = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        vecs[0] = '{0, 3'b001, 3'b000, 32'd5,         32'd7,         32'd12,        1'b0, 1'b0};
        vecs[1] = '{0, 3'b001, 3'b000, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0};
        vecs[2] = '{1, 3'b001, 3'b100, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F, 1'b0, 1'b0};
        vecs[3] = '{0, 3'b001, 3'b001, 32'd10,        32'd3,         32'd7,         1'b0, 1'b0};
        vecs[4] = '{1, 3'b001, 3'b001, 32'd3,         32'd10,        32'hFFFF_FFF9, 1'b1, 1'b0};
        vecs[5] = '{1, 3'b010, 3'b000, 32'd1,         32'd2,         32'd0,         1'b0, 1'b1};
        vecs[6] = '{0, 3'b101, 3'b000, 32'h0000_1234, 32'd0,         32'hA5A5_1234, 1'b0, 1'b0};
        vecs[7] = '{0, 3'b111, 3'b011, 32'h55,        32'h66,        32'd0,         1'b0, 1'b1};
        vecs[8] = '{1, 3'b001, 3'b010, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0};
        vecs[9] = '{0, 3'b001, 3'b011, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0};

        apply_reset();
        for (int i = 0; i < 10; i++) run_op(vecs[i], i);

        // Simultaneous requests after reset, then port 0 re-requests while port 1 waits
        apply_reset();
        cyc();
        set_req(0, 1'b1, 3'b001, 3'b001, 32'd10, 32'd3);
        set_req(1, 1'b1, 3'b001, 3'b100, 32'hF0, 32'hFF);
        @(negedge clock);
        check("both_first_grant", 64'({req1_ready, req0_ready}), 64'(2'b01));
        cyc();
        drop(0);
        wait_rsp(0, lat);
        check("both_p0_rsp", 64'({rsp0_valid, lat[3:0], rsp_err, rsp_carry, rsp_data}),
              64'({1'b1, 4'd3, 1'b0, 1'b0, 32'd7}));
        cyc();
        set_req(0, 1'b1, 3'b001, 3'b000, 32'd5, 32'd7);
        w = FIXED ? 0 : 1;
        o = 1 - w;
        @(negedge clock);
        check("both_second_grant", 64'({req1_ready, req0_ready}), 64'((w == 1) ? 2'b10 : 2'b01));
        cyc();
        drop(w);
        wait_rsp(w, lat);
        check("both_second_rsp", 64'({rspv(w), rsp_data}),
              64'({1'b1, (w == 1) ? 32'h0F : 32'd12}));
        cyc();
        @(negedge clock);
        check("both_third_grant", 64'(rdy(o)), 64'd1);
        cyc();
        drop(o);
        wait_rsp(o, lat);
        check("both_third_rsp", 64'({rspv(o), rsp_data}),
              64'({1'b1, (o == 1) ? 32'h0F : 32'd12}));
        cyc();

        // Response back-pressure with port 1 waiting
        apply_reset();
        cyc();
        set_req(0, 1'b1, 3'b001, 3'b000, 32'd100, 32'd23);
        rsp0_ready = 1'b0;
        @(negedge clock);
        check("bp_accept", 64'(req0_ready), 64'd1);
        cyc();
        drop(0);
        set_req(1, 1'b1, 3'b001, 3'b100, 32'hF0, 32'h0F);
        wait_rsp(0, lat);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold%0d", i),
                  64'({rsp0_valid, rsp1_valid, req1_ready, rsp_err, rsp_carry, rsp_data}),
                  64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd123}));
            @(negedge clock);
        end
        cyc();
        rsp0_ready = 1'b1;
        @(negedge clock);
        check("bp_handshake_cycle", 64'({rsp0_valid, req1_ready}), 64'(2'b10));
        cyc();
        @(negedge clock);
        check("bp_p1_accept_after", 64'(req1_ready), 64'd1);
        cyc();
        drop(1);
        wait_rsp(1, lat);
        check("bp_p1_rsp", 64'({rsp1_valid, rsp_data}), 64'({1'b1, 32'hFF}));
        cyc();

        // Reset during WAIT aborts the operation
        apply_reset();
        cyc();
        set_req(0, 1'b1, 3'b001, 3'b000, 32'd77, 32'd88);
        @(negedge clock);
        check("abort_accept", 64'(req0_ready), 64'd1);
        cyc();
        drop(0);
        @(negedge clock);
        check("abort_issue_enable", 64'(alu_enable), 64'd1);
        cyc();
        reset = 1'b1;
        @(negedge clock);
        check("abort_reset_outputs", outs_pack(), 64'd0);
        cyc();
        reset = 1'b0;
        @(negedge clock);
        check("abort_idle", 64'({busy, alu_reset_n}), 64'(2'b01));
        for (int i = 0; i < 6; i++) begin
            check($sformatf("abort_no_rsp%0d", i), 64'({rsp1_valid, rsp0_valid, busy}), 64'd0);
            @(negedge clock);
        end

        // Randomized traffic against a latency/arbitration model
        apply_reset();
        m_busy = 1'b0; m_ptr = 1'b0;
        m_port = 0; m_age = 0; m_lat = 0;
        rv[0] = 1'b0; rv[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            rs[p] = '0; ro[p] = '0; ra[p] = '0; rb[p] = '0;
        end
        for (int cy = 0; cy < 3000; cy++) begin
            cyc();
            for (int p = 0; p < 2; p++) begin
                if (!rv[p] && $urandom_range(0, 2) == 0) begin
                    rv[p] = 1'b1;
                    if ($urandom_range(0, 3) != 0) rs[p] = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b101;
                    else                           rs[p] = 3'($urandom);
                    ro[p] = 3'($urandom_range(0, 4));
                    ra[p] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                    rb[p] = $urandom;
                end
                set_req(p, rv[p], rs[p], ro[p], ra[p], rb[p]);
            end
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
            @(negedge clock);
            if (!m_busy) begin
                if (rv[0] && rv[1]) exp_rdy = (FIXED || !m_ptr) ? 2'b01 : 2'b10;
                else                exp_rdy = {rv[1], rv[0]};
                check("rnd_ready", 64'({req1_ready, req0_ready}), 64'(exp_rdy));
                check("rnd_idle_outs", 64'({rsp1_valid, rsp0_valid, busy, alu_enable}), 64'd0);
                if (exp_rdy != 2'b00) begin
                    m_port = exp_rdy[1] ? 1 : 0;
                    m_sel = rs[m_port]; m_op = ro[m_port]; m_a = ra[m_port]; m_b = rb[m_port];
                    if (m_sel == 3'b001 || m_sel == 3'b101) begin
                        {m_c, m_d} = alu_ref(m_sel, m_op, m_a, m_b);
                        m_e = 1'b0; m_lat = 3;
                    end else begin
                        m_c = 1'b0; m_d = '0; m_e = 1'b1; m_lat = 1;
                    end
                    m_busy = 1'b1;
                    m_age  = 0;
                    rv[m_port] = 1'b0;
                end
            end else begin
                m_age++;
                check("rnd_busy_ready", 64'({req1_ready, req0_ready, busy}), 64'(3'b001));
                exp_rv = (m_age >= m_lat) ? ((m_port == 1) ? 2'b10 : 2'b01) : 2'b00;
                check("rnd_rsp_valid", 64'({rsp1_valid, rsp0_valid}), 64'(exp_rv));
                check("rnd_alu_enable", 64'(alu_enable), 64'((m_lat == 3) && (m_age == 1)));
                if (m_lat == 3 && m_age == 1) begin
                    check("rnd_alu_operands", {aluin1, aluin2}, {m_a, m_b});
                    check("rnd_alu_op", 64'({alu_opselect, alu_operation}), 64'({m_sel, m_op}));
                end
                if (m_age >= m_lat) begin
                    check("rnd_result", 64'({rsp_err, rsp_carry, rsp_data}), 64'({m_e, m_c, m_d}));
                    if ((m_port == 1) ? rsp1_ready : rsp0_ready) begin
                        m_busy = 1'b0;
                        m_ptr  = ~m_ptr;
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the operand and result width; only 32 is supported.
REQ-002 clock  in  1  single clock; all logic updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 reqN_valid (N=0,1)  in  1  requester N has an operation pending.
REQ-005 reqN_ready  out  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_opselect / reqN_operation  in  3 / 3  opcode class and sub-operation.
REQ-007 reqN_op1 / reqN_op2  in  32 / 32  operands.
REQ-008 rspN_valid  out  1  result is available for requester N.
REQ-009 rspN_ready  in  1  requester N takes the result.
REQ-010 rsp_data / rsp_carry / rsp_err  out  32 / 1 / 1  result bus, shared by both ports.
REQ-011 alu_enable, alu_opselect[3], alu_operation[3], aluin1[32], aluin2[32]  out  drive the shared ALU.
REQ-012 alu_reset_n  out  1  equals ~reset, giving the ALU its active-low reset.
REQ-013 aluout_arith[32], carry  in  ALU registered result and carry.
REQ-014 busy  out  1  high in every state other than IDLE.

Function
REQ-015 The FSM shall have four states: IDLE, ISSUE, WAIT and RESP.
REQ-016 IDLE: if any reqN_valid is high, the arbiter shall grant one port, assert its reqN_ready for that cycle only, and latch that port's opcode and operands.
REQ-017 Priority shall be round-robin with a 1-bit pointer:
- after reset the pointer favours port 0;
- on each completed response handshake the pointer moves to the other port;
- a lone valid requester wins regardless of the pointer.
REQ-018 Accepted opselect 001 (ARITH_LOGIC) or 101 (MEM_READ): IDLE -> ISSUE.
REQ-019 Accepted opselect of any other value: IDLE -> RESP directly, the ALU is not issued, rsp_err=1, rsp_data=0, rsp_carry=0.
REQ-020 ISSUE: alu_enable=1 for exactly one cycle with the latched operands; next state WAIT.
REQ-021 WAIT: capture aluout_arith and carry into the result registers; next state RESP.
REQ-022 RESP:
- rspN_valid is asserted for the granted port only;
- rsp_data, rsp_carry and rsp_err are held stable until rspN_ready is high;
- on the handshake cycle the state returns to IDLE.
REQ-023 Latency: rspN_valid shall be asserted 3 cycles after the accept edge (1 cycle for an error response); peak throughput is one operation per 4 cycles.
REQ-024 Both reqN_ready outputs shall be low in every state except IDLE; requests arriving in other states wait and are not lost.
REQ-025 alu_enable shall be 0 outside ISSUE, and the alu_* operand outputs shall hold their last value.
REQ-026 A requester shall hold its payload stable while valid is high and ready is low; the arbiter samples the payload only on the accept cycle.
REQ-027 rspN_ready while rspN_valid is low shall be ignored.

Reset
REQ-028 With reset high at a clock edge, the arbiter shall enter IDLE and set the pointer to port 0.
REQ-029 While reset is active, every output shall be 0 except alu_reset_n, which shall be 0 for the duration of reset.
REQ-030 Reset in any state, including mid-ISSUE, WAIT or RESP, shall abort the operation; no response is ever produced for it.

Configuration
REQ-031 The macro ALU_ARB_FIXED_PRIO_EN shall select the arbitration policy:
- defined: port 0 always wins a simultaneous request and the pointer logic is removed;
- undefined: round-robin as specified in REQ-017.

Verification
REQ-032 Port 0 ADD (opselect 001, operation 000), op1=5, op2=7 -> rsp0_valid 3 cycles after accept, rsp_data=12, rsp_carry=0, rsp_err=0.
REQ-033 ADD 0xFFFFFFFF + 0x00000001 -> rsp_data=0, rsp_carry=1.
REQ-034 Both ports valid after reset, port 0 SUB 10-3 and port 1 XOR 0xF0^0xFF -> port 0 served first (data 7), then port 1 (data 0x0F); with the macro defined and port 0 re-requesting, port 0 wins again.
REQ-035 Port 1 opselect 010 -> rsp1_valid 1 cycle after accept, rsp_err=1, rsp_data=0, alu_enable never asserted.
REQ-036 rsp0_ready held low for 5 cycles with port 1 valid -> response stable, req1_ready low, port 1 accepted the cycle after the handshake.
REQ-037 Reset asserted during WAIT -> IDLE next cycle, no rspN_valid, alu_reset_n=0 while reset is high.
